// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared defines for the fetch stage (bus width, NOP, FSM encodings, queue entry)
package if_fetch_pkg;
    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    localparam logic [REG_BUS-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    typedef struct packed {
        logic [REG_BUS-1:0] pc;
        logic [REG_BUS-1:0] inst;
    } fetch_entry_t;
    function automatic logic [REG_BUS-1:0] word_align(input logic [REG_BUS-1:0] a);
        return {a[REG_BUS-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry synchronous FIFO of {pc, inst} with flush
// Ports: clk, rst (async, active-high), flush, push/push_data, pop,
//        valid/head (registered head entry), count (occupancy)
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output logic                       valid,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign valid = count != '0;
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with one outstanding request and a small instruction queue
// Ports: clk, rst (async, active-high)
//        imem_req/imem_addr -> memory request; imem_rvalid/imem_rdata <- in-order response
//        jump_en/jump_addr  <- redirect from execute
//        inst_valid/inst/inst_pc -> decode (registered); inst_ready <- decode accept
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] DEPTH_C = (QW+1)'(QDEPTH);

    logic [1:0]    state;
    logic [1:0]    cur;
    logic [1:0]    state_nx;
    logic [31:0]   fetch_pc;
    logic          inflight;
    logic          q_valid;
    fetch_entry_t  q_head;
    logic [QW:0]   count;
    logic [QW:0]   room;
    logic          pop;
    logic          push;
    logic          issue;

    // inflight deliberately has no reset: it remembers a request that was
    // outstanding when rst hit, so its late response can be dropped.
    // The reset register state is always IDLE; that memory promotes it to DROP.
    assign cur   = (state == S_IDLE && inflight) ? S_DROP : state;
    assign pop   = q_valid && inst_ready;
    assign push  = cur == S_WAIT && imem_rvalid && !jump_en;
    // occupancy after this cycle's push/pop; only meaningful while pushing
    assign room  = count + (QW+1)'(1) - (QW+1)'(pop);
    assign issue = !rst && !jump_en &&
                   ((cur == S_IDLE && count < DEPTH_C) || (push && room < DEPTH_C));

    always_comb begin
        state_nx = cur;
        if (jump_en)
            state_nx = (cur == S_WAIT) ? (imem_rvalid ? S_IDLE : S_DROP) : cur;
        else if (cur == S_IDLE)
            state_nx = issue ? S_WAIT : S_IDLE;
        else if (imem_rvalid)
            state_nx = (cur == S_WAIT && issue) ? S_WAIT : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= word_align(RESET_PC);
        end else begin
            state    <= state_nx;
            fetch_pc <= jump_en ? word_align(jump_addr) : issue ? fetch_pc + 32'd4 : fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        inflight <= state_nx != S_IDLE;
    end

    // fetch_pc has already advanced past the outstanding request
    if_fetch_queue #(.DEPTH(QDEPTH)) fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_en),
        .push      (push),
        .push_data ('{pc: fetch_pc - 32'd4, inst: imem_rdata}),
        .pop       (pop),
        .valid     (q_valid),
        .head      (q_head),
        .count     (count)
    );

    assign imem_req   = issue;
    assign imem_addr  = issue ? fetch_pc : ZERO_WORD;
    assign inst_valid = q_valid;
    assign inst       = q_valid ? q_head.inst : INST_NOP;
    assign inst_pc    = q_valid ? q_head.pc : ZERO_WORD;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: table-driven directed bench for if_fetch plus reset/wrap sequences
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D   = 32'hABC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;

    logic        rst2 = 1'b1;
    logic        req2;
    logic [31:0] addr2;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = '0;
    logic        iv2;
    logic [31:0] inst2;
    logic [31:0] pc2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .jump_en(jump_en),
        .jump_addr(jump_addr), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rv2), .imem_rdata(rd2), .jump_en(1'b0),
        .jump_addr(32'h0), .inst_valid(iv2), .inst(inst2),
        .inst_pc(pc2), .inst_ready(1'b1)
    );

    typedef struct {
        logic        r, rv, je, rdy;
        logic [31:0] rd, ja;
        logic        req, iv;
        logic [31:0] addr, ins, pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, rv, input logic [31:0] rd, input logic je,
                       input logic [31:0] ja, input logic rdy, req,
                       input logic [31:0] addr, input logic iv, input logic [31:0] ins, pc);
        vecs.push_back('{r: r, rv: rv, je: je, rdy: rdy, rd: rd, ja: ja,
                         req: req, iv: iv, addr: addr, ins: ins, pc: pc});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  r rv rd        je ja        rdy | req addr       iv ins       pc
        add(1, 0, 0,        0, 0,        1,   0, 0,          0, NOP,      0);
        // back-to-back fetch with decode always ready
        add(0, 0, 0,        0, 0,        1,   1, 0,          0, NOP,      0);
        add(0, 1, D,        0, 0,        1,   1, 4,          0, NOP,      0);
        add(0, 1, D+4,      0, 0,        1,   1, 8,          1, D,        0);
        add(0, 1, D+8,      0, 0,        1,   1, 32'hC,      1, D+4,      4);
        add(0, 1, D+32'hC,  0, 0,        0,   0, 0,          1, D+8,      8);
        add(0, 0, 0,        0, 0,        0,   0, 0,          1, D+8,      8);
        add(1, 0, 0,        0, 0,        0,   0, 0,          0, NOP,      0);
        // decode stalled for 10 cycles: queue fills after two requests
        add(0, 0, 0,        0, 0,        0,   1, 0,          0, NOP,      0);
        add(0, 1, D,        0, 0,        0,   1, 4,          0, NOP,      0);
        add(0, 1, D+4,      0, 0,        0,   0, 0,          1, D,        0);
        for (int k = 0; k < 7; k++)
            add(0, 0, 0,    0, 0,        0,   0, 0,          1, D,        0);
        add(0, 0, 0,        0, 0,        1,   0, 0,          1, D,        0);
        add(0, 0, 0,        0, 0,        1,   1, 8,          1, D+4,      4);
        // jump while request at 8 outstanding; low target bits ignored
        add(0, 0, 0,        1, 32'h101,  1,   0, 0,          0, NOP,      0);
        add(0, 1, 32'hDEADBEEF, 0, 0,    1,   0, 0,          0, NOP,      0);
        add(0, 0, 0,        0, 0,        1,   1, 32'h100,    0, NOP,      0);
        add(0, 1, D+32'h100, 0, 0,       1,   1, 32'h104,    0, NOP,      0);
        // jump coinciding with rvalid: response discarded, queue flushed
        add(0, 1, D+32'h104, 1, 32'h200, 1,   0, 0,          1, D+32'h100, 32'h100);
        add(0, 0, 0,        0, 0,        1,   1, 32'h200,    0, NOP,      0);
        add(0, 1, D+32'h200, 0, 0,       1,   1, 32'h204,    0, NOP,      0);
        add(0, 0, 0,        0, 0,        1,   0, 0,          1, D+32'h200, 32'h200);
        add(0, 1, D+32'h204, 0, 0,       1,   1, 32'h208,    0, NOP,      0);

        repeat (2) next_cycle();
        foreach (vecs[i]) begin
            rst = vecs[i].r;
            imem_rvalid = vecs[i].rv;
            imem_rdata = vecs[i].rd;
            jump_en = vecs[i].je;
            jump_addr = vecs[i].ja;
            inst_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
            check($sformatf("row%0d inst", i), inst, vecs[i].ins);
            check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].pc);
            next_cycle();
        end

        // reset with the request at 0x208 outstanding; its late response must be dropped
        imem_rvalid = 0; jump_en = 0; inst_ready = 1; rst = 1;
        @(negedge clk);
        check("rst_mid imem_req", 32'(imem_req), 0);
        check("rst_mid imem_addr", imem_addr, 0);
        check("rst_mid inst_valid", 32'(inst_valid), 0);
        check("rst_mid inst", inst, NOP);
        check("rst_mid inst_pc", inst_pc, 0);
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("drop_wait imem_req", 32'(imem_req), 0);
        next_cycle();
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("drop_rsp imem_req", 32'(imem_req), 0);
        next_cycle();
        imem_rvalid = 0;
        @(negedge clk);
        check("after_drop inst_valid", 32'(inst_valid), 0);
        check("after_drop imem_req", 32'(imem_req), 1);
        check("after_drop imem_addr", imem_addr, 0);
        next_cycle();
        imem_rvalid = 1; imem_rdata = D;
        @(negedge clk);
        check("refetch imem_addr", imem_addr, 4);
        next_cycle();
        imem_rvalid = 0;
        @(negedge clk);
        check("refetch inst_valid", 32'(inst_valid), 1);
        check("refetch inst_pc", inst_pc, 0);
        check("refetch inst", inst, D);
        next_cycle();

        // fetch_pc wraps from 0xFFFF_FFFC to 0
        rst2 = 0;
        @(negedge clk);
        check("wrap req0", 32'(req2), 1);
        check("wrap addr0", addr2, 32'hFFFF_FFFC);
        next_cycle();
        rv2 = 1; rd2 = 32'h1122_3344;
        @(negedge clk);
        check("wrap req1", 32'(req2), 1);
        check("wrap addr1", addr2, 32'h0000_0000);
        next_cycle();
        rd2 = 32'h5566_7788;
        @(negedge clk);
        check("wrap inst_valid", 32'(iv2), 1);
        check("wrap inst_pc", pc2, 32'hFFFF_FFFC);
        check("wrap inst", inst2, 32'h1122_3344);
        check("wrap addr2", addr2, 32'h0000_0004);
        next_cycle();
        rv2 = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 2: instruction queue depth (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req, output, 1: one-cycle fetch request pulse.
REQ-006 SHALL have port imem_addr, output, 32: word-aligned fetch address, valid while imem_req=1.
REQ-007 SHALL have port imem_rvalid, input, 1: read data valid; in order, at least 1 cycle after the request.
REQ-008 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-009 SHALL have port jump_en, input, 1: redirect request from the execute stage.
REQ-010 SHALL have port jump_addr, input, 32: redirect target.
REQ-011 SHALL have port inst_valid, output, 1: the queue head is presented to decode.
REQ-012 SHALL have port inst, output, 32: instruction to decode; INST_NOP (32'h0000_0013) when inst_valid=0.
REQ-013 SHALL have port inst_pc, output, 32: PC of inst; 0 when inst_valid=0.
REQ-014 SHALL have port inst_ready, input, 1: decode accepts the head this cycle.

Function
REQ-015 SHALL hold at most one outstanding memory request; the memory always accepts imem_req.
REQ-016 SHALL implement FSM IDLE / WAIT / DROP; reset state IDLE.
REQ-017 SHALL, in IDLE with no jump, issue imem_req at fetch_pc only when count + outstanding < QDEPTH; then fetch_pc += 4 and go to WAIT.
REQ-018 SHALL, in WAIT on imem_rvalid, push {fetch address, imem_rdata}; if space remains and there is no jump, issue the next request in the same cycle (back-to-back) and stay in WAIT, else go to IDLE.
REQ-019 SHALL, on jump_en in WAIT without imem_rvalid: set fetch_pc=jump_addr, flush the queue, go to DROP, no request that cycle.
REQ-020 SHALL, in DROP on imem_rvalid: discard the data; go to IDLE (next request the following cycle).
REQ-021 SHALL, on jump_en coinciding with imem_rvalid in WAIT: discard the response, flush, set fetch_pc=jump_addr, go to IDLE.
REQ-022 SHALL, on jump_en in IDLE or DROP: flush and set fetch_pc=jump_addr; state is unchanged, and no request is issued that cycle.
REQ-023 SHALL pop the head when inst_valid && inst_ready; a simultaneous push and pop leaves count unchanged.
REQ-024 SHALL give jump_en priority over push, pop and issue in the same cycle; a decode handshake in that cycle still completes for that word.
REQ-025 SHALL drive inst, inst_pc and inst_valid from registered queue state, with no combinational path from imem_rdata or inst_ready.
REQ-026 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0); queue pointers wrap modulo QDEPTH.
REQ-027 SHALL ignore jump_addr[1:0] and force imem_addr[1:0]=0.
REQ-028 SHALL give fetch latency: a request in cycle N with rvalid in N+1 gives inst_valid in N+2.

Reset
REQ-029 SHALL on rst: state=IDLE, fetch_pc=RESET_PC, queue empty, outstanding=0, imem_req=0, imem_addr=0, inst_valid=0, inst=INST_NOP, inst_pc=0.
REQ-030 SHALL, when rst is asserted mid-transaction, drop any in-flight response arriving after rst deasserts; this is tracked by entering DROP if a request was outstanding at rst assertion.
REQ-031 SHALL issue the first request in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place INST_NOP, RegBus width and ZeroWord in the shared defines include, and FSM state encodings there as well.
REQ-033 SHALL instantiate one sub-module, fetch_queue (QDEPTH-entry synchronous FIFO of {pc, inst} with flush).

Verification
REQ-034 Reset release, 1-cycle memory, inst_ready=1 -> imem_addr 0,4,8 on consecutive cycles; inst_valid from cycle 2 with inst_pc 0,4,8.
REQ-035 inst_ready=0 for 10 cycles -> exactly 2 requests (0, 4); queue full; no imem_req until inst_ready=1.
REQ-036 jump_en with jump_addr=32'h100 while the request at 8 is outstanding -> response discarded, next imem_addr=32'h100, first valid inst_pc=32'h100.
REQ-037 jump_en coinciding with imem_rvalid -> no push; queue empty next cycle; next request at jump_addr.
REQ-038 RESET_PC=32'hFFFF_FFFC -> second request address 32'h0000_0000.
REQ-039 rst asserted with a request outstanding and a late rvalid after release -> data discarded; first inst_pc=RESET_PC.
